// File: rtl/point_arbiter.sv
// Turns two asynchronous active-low player buttons into single-cycle point pulses,
// with tie arbitration, lockout and release wait. Press-to-pulse latency is 3 edges; no backpressure.
module point_arbiter #(
    parameter int LOCKOUT_CYCLES = 12_500_000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_n,
    input  logic       p2_n,
    input  logic       hold,
    output logic       p1_point,
    output logic       p2_point,
    output logic       busy,
    output logic [7:0] drop_count
);

    typedef enum logic [2:0] {IDLE, GRANT1, GRANT2, LOCKOUT, WAIT_REL} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;          // 0 = player 1 wins a tie, 1 = player 2
    logic             s1_meta_q, s1_q, d1_q;
    logic             s2_meta_q, s2_q, d2_q;
    logic             p1_point_q, p2_point_q, busy_q;
    logic [7:0]       drop_q, drop_d;
    logic             edge1, edge2;
    logic [1:0]       drop_inc;
    logic [8:0]       drop_sum;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (!hold) begin
                    if (!s1_q && !s2_q)
                        state_d = ptr_q ? GRANT2 : GRANT1;
                    else if (!s1_q)
                        state_d = GRANT1;
                    else if (!s2_q)
                        state_d = GRANT2;
                end
            end
            GRANT1: begin
                cnt_d   = CNT_LOAD;
                ptr_d   = 1'b1;
                state_d = LOCKOUT;
            end
            GRANT2: begin
                cnt_d   = CNT_LOAD;
                ptr_d   = 1'b0;
                state_d = LOCKOUT;
            end
            LOCKOUT: begin
                if (cnt_q == '0)
                    state_d = WAIT_REL;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            WAIT_REL: begin
                if (s1_q && s2_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only fresh press edges are counted, so the held grant press never counts as a drop.
    always_comb begin
        edge1    = d1_q & ~s1_q;
        edge2    = d2_q & ~s2_q;
        drop_inc = {1'b0, edge1} + {1'b0, edge2};
        drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d   = drop_q;
        if (state_q == LOCKOUT || state_q == WAIT_REL)
            drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_meta_q  <= 1'b1;
            s1_q       <= 1'b1;
            d1_q       <= 1'b1;
            s2_meta_q  <= 1'b1;
            s2_q       <= 1'b1;
            d2_q       <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            drop_q     <= 8'd0;
            p1_point_q <= 1'b0;
            p2_point_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_meta_q  <= p1_n;
            s1_q       <= s1_meta_q;
            d1_q       <= s1_q;
            s2_meta_q  <= p2_n;
            s2_q       <= s2_meta_q;
            d2_q       <= s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            drop_q     <= drop_d;
            p1_point_q <= (state_d == GRANT1);
            p2_point_q <= (state_d == GRANT2);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign p1_point   = p1_point_q;
    assign p2_point   = p2_point_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_point_arbiter.sv
// Directed bench for point_arbiter with an 8-cycle lockout; inputs change on the falling edge.
module tb_point_arbiter;

    logic       clk;
    logic       rst;
    logic       p1_n;
    logic       p2_n;
    logic       hold;
    logic       p1_point;
    logic       p2_point;
    logic       busy;
    logic [7:0] drop_count;

    int errors = 0;
    int checks = 0;

    point_arbiter #(.LOCKOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .p1_n       (p1_n),
        .p2_n       (p2_n),
        .hold       (hold),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .busy       (busy),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        p1_n = 1'b1;
        p2_n = 1'b1;
        hold = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 40) begin
            if (!busy) ok = 1'b1;
            else begin
                tick(1);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (p1_point !== 1'b0) begin errors++; $display("FAIL reset_p1_point got %b want 0", p1_point); end
        checks++; if (p2_point !== 1'b0) begin errors++; $display("FAIL reset_p2_point got %b want 0", p2_point); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    endtask

    task automatic test_single_press();
        int p1c, p2c, first, bc;
        p1c = 0; p2c = 0; first = 0; bc = 0;
        p1_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (p1_point === 1'b1) begin
                p1c++;
                if (first == 0) first = i;
            end
            if (p2_point === 1'b1) p2c++;
            if (busy === 1'b1) bc++;
        end
        checks++; if (p1c != 1) begin errors++; $display("FAIL single_p1_count got %0d want 1", p1c); end
        checks++; if (first != 3) begin errors++; $display("FAIL single_latency got %0d want 3", first); end
        checks++; if (bc != 18) begin errors++; $display("FAIL single_busy_cycles got %0d want 18", bc); end
        checks++; if (p2c != 0) begin errors++; $display("FAIL single_p2_count got %0d want 0", p2c); end
        p1_n = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL release_busy_early got %b want 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_tie();
        bit ok;
        do_reset();
        p1_n = 1'b0; p2_n = 1'b0;
        tick(3);
        checks++; if (p1_point !== 1'b1) begin errors++; $display("FAIL tie1_p1 got %b want 1", p1_point); end
        checks++; if (p2_point !== 1'b0) begin errors++; $display("FAIL tie1_p2 got %b want 0", p2_point); end
        tick(12);
        p1_n = 1'b1; p2_n = 1'b1;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tie1_idle timeout busy=%b want 0", busy); end
        p1_n = 1'b0; p2_n = 1'b0;
        tick(3);
        checks++; if (p2_point !== 1'b1) begin errors++; $display("FAIL tie2_p2 got %b want 1", p2_point); end
        checks++; if (p1_point !== 1'b0) begin errors++; $display("FAIL tie2_p1 got %b want 0", p1_point); end
        tick(12);
        p1_n = 1'b1; p2_n = 1'b1;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tie2_idle timeout busy=%b want 0", busy); end
    endtask

    task automatic test_drop();
        int p1c, p2c;
        p1c = 0; p2c = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            p1_n = (i == 0) ? 1'b0 : 1'b1;
            p2_n = (i == 3 || i == 5 || i == 7) ? 1'b0 : 1'b1;
            tick(1);
            if (p1_point === 1'b1) p1c++;
            if (p2_point === 1'b1) p2c++;
        end
        checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL drop_count got %0d want 3", drop_count); end
        checks++; if (p1c != 1) begin errors++; $display("FAIL drop_p1_count got %0d want 1", p1c); end
        checks++; if (p2c != 0) begin errors++; $display("FAIL drop_p2_count got %0d want 0", p2c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got %b want 0", busy); end
    endtask

    task automatic test_hold();
        int p2c, bc;
        bit ok;
        p2c = 0; bc = 0;
        hold = 1'b1;
        p2_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (p2_point === 1'b1) p2c++;
            if (busy === 1'b1) bc++;
        end
        checks++; if (p2c != 0) begin errors++; $display("FAIL hold_p2_count got %0d want 0", p2c); end
        checks++; if (bc != 0) begin errors++; $display("FAIL hold_busy got %0d want 0", bc); end
        checks++; if (drop_count !== 8'd3) begin errors++; $display("FAIL hold_drop got %0d want 3", drop_count); end
        hold = 1'b0;
        tick(1);
        checks++; if (p2_point !== 1'b1) begin errors++; $display("FAIL unhold_p2 got %b want 1", p2_point); end
        tick(1);
        checks++; if (p2_point !== 1'b0) begin errors++; $display("FAIL unhold_p2_single got %b want 0", p2_point); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unhold_busy got %b want 1", busy); end
        p2_n = 1'b1;
        tick(12);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_idle timeout busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int pc, bc;
        bit ok;
        pc = 0; bc = 0;
        p1_n = 1'b0;
        tick(5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
        rst  = 1'b0;
        p1_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async got %b want 0", busy); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_drop_async got %0d want 0", drop_count); end
        tick(2);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (p1_point === 1'b1 || p2_point === 1'b1) pc++;
            if (busy === 1'b1) bc++;
        end
        checks++; if (pc != 0) begin errors++; $display("FAIL mid_no_pulse got %0d want 0", pc); end
        checks++; if (bc != 0) begin errors++; $display("FAIL mid_no_busy got %0d want 0", bc); end
        p1_n = 1'b0;
        tick(3);
        checks++; if (p1_point !== 1'b1) begin errors++; $display("FAIL mid_regrant got %b want 1", p1_point); end
        p1_n = 1'b1;
        tick(12);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_idle timeout busy=%b want 0", busy); end
    endtask

    task automatic test_saturate();
        int p2c;
        bit ok;
        p2c = 0;
        do_reset();
        p1_n = 1'b0;
        tick(15);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_wait_rel got %b want 1", busy); end
        for (int i = 0; i < 100; i++) begin
            p2_n = 1'b0; tick(1); if (p2_point === 1'b1) p2c++;
            p2_n = 1'b1; tick(1); if (p2_point === 1'b1) p2c++;
        end
        tick(4);
        checks++; if (drop_count !== 8'd100) begin errors++; $display("FAIL sat_mid got %0d want 100", drop_count); end
        for (int i = 0; i < 200; i++) begin
            p2_n = 1'b0; tick(1); if (p2_point === 1'b1) p2c++;
            p2_n = 1'b1; tick(1); if (p2_point === 1'b1) p2c++;
        end
        tick(4);
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", drop_count); end
        checks++; if (p2c != 0) begin errors++; $display("FAIL sat_p2_count got %0d want 0", p2c); end
        p1_n = 1'b1;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sat_idle timeout busy=%b want 0", busy); end
    endtask

    initial begin
        rst  = 1'b0;
        p1_n = 1'b1;
        p2_n = 1'b1;
        hold = 1'b0;
        test_reset();
        test_single_press();
        test_tie();
        test_drop();
        test_hold();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
